week5_gate_checker: RTL
=======================

WEEK5_GATE_CHECKER -- requirements
Module: week5_gate_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 1: number of inputs of the gate under test (1..4).
REQ-002 SHALL have parameter SETTLE, default 2: clock cycles each vector is held before its output is sampled (1..15).
REQ-003 SHALL have parameter TRUTH, default 2'b01, width 2^WIDTH: expected output, where bit i is the expected dut_y for input vector i (default encodes NOT).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-007 SHALL have port dut_a  output  WIDTH  input vector driven to the gate under test.
REQ-008 SHALL have port dut_y  input  1  output returned by the gate under test.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-011 SHALL have port pass  output  1  high when the last run completed with fail_count==0; valid from done onward.
REQ-012 SHALL have ports pass_count and fail_count  output  WIDTH+1 each  vectors matched / mismatched in the current or last run.
REQ-013 SHALL have port fail_vec  output  WIDTH  first mismatching vector; fail_valid  output  1  high once fail_vec is captured.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-015 IDLE with start=1 SHALL clear counters, pass, fail_valid and fail_vec, set dut_a=0, load the settle counter with SETTLE-1, and go to SETTLE.
REQ-016 SETTLE SHALL decrement the settle counter each cycle and go to SAMPLE on the cycle it reads 0.
REQ-017 SAMPLE SHALL compare dut_y to TRUTH[dut_a]; on match it increments pass_count, otherwise fail_count.
REQ-018 On the first mismatch of a run, SAMPLE SHALL load fail_vec=dut_a and set fail_valid=1; later mismatches leave both unchanged.
REQ-019 SAMPLE with dut_a==2^WIDTH-1 SHALL go to DONE; otherwise it SHALL increment dut_a, reload the settle counter, and go to SETTLE.
REQ-020 DONE SHALL assert done for exactly one cycle, set pass=(fail_count==0) using the final count, and return to IDLE.
REQ-021 done SHALL be observed high immediately after the 2^WIDTH*(SETTLE+1)-th rising edge following the edge that sampled start.
REQ-022 start SHALL be ignored while busy, including in the DONE cycle.
REQ-023 dut_a SHALL hold its last vector in IDLE after a run; counters and pass SHALL hold until the next accepted start.
REQ-024 Counters SHALL not wrap, because WIDTH+1 bits covers 2^WIDTH.

Reset
REQ-025 rst_n low SHALL immediately force IDLE and set dut_a=0, busy=0, done=0, pass=0, pass_count=0, fail_count=0, fail_vec=0, fail_valid=0, including in the middle of a run.
REQ-026 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-027 Macro GATE_CHK_STOP_ON_FAIL_EN SHALL control stopping on a failure.
REQ-028 With GATE_CHK_STOP_ON_FAIL_EN defined, the first mismatch SHALL send SAMPLE directly to DONE, and the remaining vectors SHALL not be applied.
REQ-029 Without GATE_CHK_STOP_ON_FAIL_EN, every vector SHALL always be applied.

Verification
REQ-030 Bench SHALL check: defaults, dut_y=~dut_a, start pulse -> done 6 edges later, pass_count=2, fail_count=0, pass=1, fail_valid=0.
REQ-031 Bench SHALL check: defaults, dut_y tied 1 -> pass_count=1, fail_count=1, fail_vec=1, fail_valid=1, pass=0.
REQ-032 Bench SHALL check: WIDTH=2, TRUTH=4'b1000, dut_y=&dut_a, SETTLE=1 -> done after 8 edges, pass_count=4, pass=1.
REQ-033 Bench SHALL check: rst_n low during the second SETTLE -> all outputs 0 at once; a new start then gives a clean full run.
REQ-034 Bench SHALL check: start repeated while busy -> no restart, done still at edge 6.
REQ-035 Bench SHALL check with GATE_CHK_STOP_ON_FAIL_EN defined: WIDTH=2, dut_y tied 0, TRUTH=4'b1111 -> done 3 edges after start, fail_count=1, fail_vec=0, dut_a stays 0.

Source files
------------

// File: rtl/week5_gate_checker.sv
`default_nettype none
// ============================================================================
// Module  : week5_gate_checker
// Brief   : Walks every input vector of a small gate, waits for it to settle,
//           and scores dut_y against the TRUTH table.
//           Optional macro GATE_CHK_STOP_ON_FAIL_EN ends a run at its first
//           mismatch.
// Revision: 1.0 - initial release
// ============================================================================
module week5_gate_checker #(
   parameter int                        WIDTH  = 1,
   parameter int                        SETTLE = 2,
   parameter logic [(1<<WIDTH)-1:0]     TRUTH  = 2'b01
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] dut_a,
   input  logic             dut_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH:0]   pass_count,
   output logic [WIDTH:0]   fail_count,
   output logic [WIDTH-1:0] fail_vec,
   output logic             fail_valid
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0]       c_settle_ld = 4'(SETTLE - 1);
   localparam logic [WIDTH:0]   c_cnt_one   = (WIDTH + 1)'(1);
   localparam logic [WIDTH-1:0] c_vec_one   = WIDTH'(1);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
   localparam logic c_stop_on_fail = 1'b1;
`else
   localparam logic c_stop_on_fail = 1'b0;
`endif

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] dut_a_q, dut_a_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [WIDTH:0]   pass_count_q, pass_count_d;
   logic [WIDTH:0]   fail_count_q, fail_count_d;
   logic [WIDTH-1:0] fail_vec_q, fail_vec_d;
   logic             fail_valid_q, fail_valid_d;
   logic             match;
   logic             last_vec;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      dut_a_d      = dut_a_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      pass_d       = pass_q;
      pass_count_d = pass_count_q;
      fail_count_d = fail_count_q;
      fail_vec_d   = fail_vec_q;
      fail_valid_d = fail_valid_q;
      match        = (dut_y == TRUTH[dut_a_q]);
      last_vec     = (dut_a_q == {WIDTH{1'b1}});

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               pass_count_d = '0;
               fail_count_d = '0;
               pass_d       = 1'b0;
               fail_valid_d = 1'b0;
               fail_vec_d   = '0;
               dut_a_d      = '0;
               cnt_d        = c_settle_ld;
               busy_d       = 1'b1;
               state_d      = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == 4'd0) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_SAMPLE: begin
            if (match) begin
               pass_count_d = pass_count_q + c_cnt_one;
            end else begin
               fail_count_d = fail_count_q + c_cnt_one;
               if (!fail_valid_q) begin
                  fail_vec_d   = dut_a_q;
                  fail_valid_d = 1'b1;
               end
            end
            // pass is decided here so it already reflects this last sample
            if (last_vec || (c_stop_on_fail && !match)) begin
               done_d  = 1'b1;
               pass_d  = (fail_count_d == '0);
               state_d = S_DONE;
            end else begin
               dut_a_d = dut_a_q + c_vec_one;
               cnt_d   = c_settle_ld;
               state_d = S_SETTLE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         dut_a_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         pass_count_q <= '0;
         fail_count_q <= '0;
         fail_vec_q   <= '0;
         fail_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dut_a_q      <= dut_a_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         pass_count_q <= pass_count_d;
         fail_count_q <= fail_count_d;
         fail_vec_q   <= fail_vec_d;
         fail_valid_q <= fail_valid_d;
      end
   end

   assign dut_a      = dut_a_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign pass_count = pass_count_q;
   assign fail_count = fail_count_q;
   assign fail_vec   = fail_vec_q;
   assign fail_valid = fail_valid_q;

endmodule
`default_nettype wire
